rift_img_loader: RTL and testbench
==================================

RIFT_IMG_LOADER -- requirements
Module: rift_img_loader

Interface
REQ-001 Parameter BASE_ADDR, default 64'h8000_0000, byte address of the first image byte; SHALL be 64-byte aligned.
REQ-002 Parameter BURST_WORDS, default 8, maximum beats per AXI burst; legal range 1..16.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RSTn  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; begins a load at BASE_ADDR.
REQ-006 in_valid / in_ready  in / out  1 / 1  byte-stream handshake; a byte transfers when both are high.
REQ-007 in_data  in  8  image byte, in ascending address order.
REQ-008 in_last  in  1  qualifies the final image byte.
REQ-009 busy / done / err  out  1 / 1 / 1  load in progress / one-cycle completion pulse / sticky write-error flag.
REQ-010 M_AXI_AWADDR  out  64; M_AXI_AWLEN  out  8; M_AXI_AWSIZE  out  3, constant 3'b011; M_AXI_AWBURST  out  2, constant 2'b01 (INCR); M_AXI_AWVALID  out  1; M_AXI_AWREADY  in  1.
REQ-011 M_AXI_WDATA  out  64; M_AXI_WSTRB  out  8, constant 8'hFF; M_AXI_WLAST  out  1; M_AXI_WVALID  out  1; M_AXI_WREADY  in  1.
REQ-012 M_AXI_BRESP  in  2; M_AXI_BVALID  in  1; M_AXI_BREADY  out  1.

Function
REQ-013 The block SHALL implement states IDLE, FILL, ADDR, DATA, RESP, DONE.
REQ-014 IDLE: start=1 -> FILL; the block SHALL load the burst address with BASE_ADDR and clear err; other inputs are ignored.
REQ-015 FILL: in_ready=1; each accepted byte SHALL be packed little-endian, so byte k of a word lands in WDATA[8k+7:8k].
REQ-016 Buffer: BURST_WORDS x 64-bit registers, a 3-bit byte counter and a word counter; the word counter SHALL advance when byte 7 of a word is accepted.
REQ-017 FILL -> ADDR when the buffer holds BURST_WORDS complete words, or on the cycle in_last is accepted.
REQ-018 On in_last, a partial word SHALL count as a word, with unwritten bytes zero; the word count is then 1..BURST_WORDS.
REQ-019 ADDR: AWVALID=1 with AWADDR = burst address and AWLEN = words-1, held stable until AWREADY; then -> DATA.
REQ-020 DATA: WVALID=1 and WDATA = buffer[beat]; the beat SHALL advance on WREADY; WLAST=1 only on beat words-1; the handshake of the last beat -> RESP.
REQ-021 AW and W SHALL be sequential; WVALID is never asserted before the AW handshake completes.
REQ-022 RESP: BREADY=1; on BVALID, BRESP!=2'b00 SHALL set err; the burst address SHALL advance by words*8; buffer counters clear.
REQ-023 RESP exit: -> DONE if the burst closed on in_last, else -> FILL.
REQ-024 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-025 in_ready SHALL be 0 in every state except FILL; busy SHALL be 1 in FILL, ADDR, DATA and RESP.
REQ-026 start while busy SHALL be ignored.
REQ-027 err SHALL remain set until the next accepted start or reset; an error SHALL NOT abort the load.
REQ-028 A buffer that fills exactly on the in_last byte SHALL produce one burst, not an extra empty burst.
REQ-029 Zero-length bursts SHALL never be issued.

Reset
REQ-030 RSTn=0 at a clock edge SHALL force IDLE and clear all counters and the buffer valid state.
REQ-031 While in reset, busy, done, err, in_ready, AWVALID, WVALID, WLAST and BREADY SHALL be 0, and AWADDR SHALL equal BASE_ADDR.
REQ-032 Reset mid-burst SHALL drop the outstanding transaction with no further AXI valids; recovery is the system's responsibility.

Verification
REQ-033 start, then 16 bytes 0x00..0x0F with in_last on 0x0F -> one burst, AWADDR=BASE_ADDR, AWLEN=1, WDATA 0x0706050403020100 then 0x0F0E0D0C0B0A0908 with WLAST on the second beat, done pulse once.
REQ-034 65 bytes 0x00..0x40 with last -> burst 1 AWADDR=BASE, AWLEN=7; burst 2 AWADDR=BASE+0x40, AWLEN=0, WDATA=0x0000000000000040, WLAST=1.
REQ-035 Hold AWREADY=0 for 5 cycles and toggle WREADY every other cycle -> AWVALID/AWADDR stable, WDATA stable while WVALID&!WREADY, in_ready=0 throughout, byte order intact.
REQ-036 BRESP=2'b10 on burst 1 of 2 -> err=1 after that response, burst 2 still issued, done pulses, err stays 1 until the next start.
REQ-037 Assert RSTn=0 during DATA beat 3 -> next cycle WVALID=0, busy=0, state IDLE; a new start reloads from BASE_ADDR correctly.
REQ-038 Exactly 64 bytes with in_last on byte 63 -> exactly one burst (AWLEN=7) and no zero-length burst.

Source files
------------

// File: rtl/rift_img_loader.sv
// Byte-stream image loader: packs incoming bytes little-endian into 64-bit words
// and writes them to memory as AXI4 INCR bursts starting at BASE_ADDR.
module rift_img_loader #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          BURST_WORDS = 8
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic [2:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [63:0] M_AXI_WDATA,
  output logic [7:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY
);

  localparam int            IW       = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BURST_WORDS - 1);

  typedef enum logic [2:0] {IDLE, FILL, ADDR, DATA, RESP, DONE} state_t;

  state_t        state;
  logic [63:0]   addr;
  logic [7:0]    awlen;
  logic [2:0]    bcnt;
  logic [IW-1:0] wcnt;
  logic [IW-1:0] beat;
  logic          last_seen;
  logic          accept;
  logic [63:0]   wbuf [BURST_WORDS];

  assign accept = in_ready & in_valid;

  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWLEN   = awlen;
  assign M_AXI_AWSIZE  = 3'b011;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WSTRB   = 8'hFF;
  assign M_AXI_WDATA   = wbuf[beat];

  // Byte 0 of a word rewrites the whole word so a short final word is zero-padded.
  always_ff @(posedge CLK) begin
    if (RSTn && accept) begin
      if (bcnt == 3'd0)
        wbuf[wcnt] <= {56'd0, in_data};
      else
        wbuf[wcnt][{bcnt, 3'b000} +: 8] <= in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state         <= IDLE;
      addr          <= BASE_ADDR;
      awlen         <= 8'd0;
      bcnt          <= 3'd0;
      wcnt          <= '0;
      beat          <= '0;
      last_seen     <= 1'b0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_WLAST   <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FILL;
            addr      <= BASE_ADDR;
            err       <= 1'b0;
            bcnt      <= 3'd0;
            wcnt      <= '0;
            last_seen <= 1'b0;
            busy      <= 1'b1;
            in_ready  <= 1'b1;
          end
        end

        FILL: begin
          if (accept) begin
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7)
              wcnt <= wcnt + IW'(1);
            // A word completed on in_last and a full buffer both close the burst here,
            // so a buffer that fills on the last byte never leaves an empty burst behind.
            if (in_last || (bcnt == 3'd7 && wcnt == LAST_IDX)) begin
              state         <= ADDR;
              in_ready      <= 1'b0;
              awlen         <= 8'(wcnt);
              last_seen     <= in_last;
              M_AXI_AWVALID <= 1'b1;
            end
          end
        end

        ADDR: begin
          if (M_AXI_AWREADY) begin
            state         <= DATA;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_WLAST   <= (awlen == 8'd0);
            beat          <= '0;
          end
        end

        DATA: begin
          if (M_AXI_WREADY) begin
            if (M_AXI_WLAST) begin
              state        <= RESP;
              M_AXI_WVALID <= 1'b0;
              M_AXI_WLAST  <= 1'b0;
              M_AXI_BREADY <= 1'b1;
            end else begin
              beat        <= beat + IW'(1);
              M_AXI_WLAST <= (8'(beat) + 8'd1 == awlen);
            end
          end
        end

        RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != 2'b00)
              err <= 1'b1;
            addr <= addr + {53'd0, awlen + 8'd1, 3'b000};
            bcnt <= 3'd0;
            wcnt <= '0;
            if (last_seen) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rift_img_loader.sv
// Directed bench for rift_img_loader: byte-level burst model feeds AW/W scoreboards,
// a responsive AXI slave, and protocol/stability monitors.
module tb_rift_img_loader;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          BW   = 8;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        busy, done, err;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  rift_img_loader #(.BASE_ADDR(BASE), .BURST_WORDS(BW)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .busy(busy), .done(done), .err(err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  logic [63:0] exp_awaddr_q[$];
  logic [7:0]  exp_awlen_q[$];
  logic [63:0] exp_wdata_q[$];
  logic        exp_wlast_q[$];

  // Slave configuration and monitor state
  int aw_delay = 0;
  int aw_wait = 0;
  bit w_toggle = 1'b0;
  bit tog = 1'b0;
  int w_stall_after = 1000;
  int err_burst = -1;
  int b_cnt = 0;
  int w_beat_cnt = 0;
  int done_cnt = 0;
  int aw_stall = 0;
  int last_aw_stall = 0;
  int start_at = -1;
  bit aw_open = 1'b0;
  bit pa_v = 1'b0, pa_r = 1'b0, pw_v = 1'b0, pw_r = 1'b0, pdone = 1'b0;
  logic [63:0] pa_addr, pw_data;
  logic [7:0]  pa_len;
  logic        pw_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [7:0] pat, input int i);
    return pat + 8'(i);
  endfunction

  // Expected bursts derived directly from the byte stream: 64 bytes per burst.
  task automatic push_expect(input int n, input logic [7:0] pat);
    int nb = (n + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      int lo = b * 64;
      int hi = (lo + 64 < n) ? lo + 64 : n;
      int words = (hi - lo + 7) / 8;
      exp_awaddr_q.push_back(BASE + 64'(b) * 64'd64);
      exp_awlen_q.push_back(8'(words - 1));
      for (int w = 0; w < words; w++) begin
        logic [63:0] d = 64'd0;
        for (int k = 0; k < 8; k++) begin
          int idx = lo + w * 8 + k;
          if (idx < hi) d[8*k +: 8] = byte_at(pat, idx);
        end
        exp_wdata_q.push_back(d);
        exp_wlast_q.push_back(w == words - 1);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic drive_bytes(input int n, input logic [7:0] pat);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      in_valid = 1'b1;
      in_data  = byte_at(pat, i);
      in_last  = (i == n - 1);
      start    = (i == start_at);
      @(negedge CLK);
      while (!in_ready && t < 500) begin
        @(negedge CLK);
        t++;
      end
      if (t >= 500) check("in_ready_timeout", 64'(i), 64'hFFFF);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_load(input string tag, input int n, input logic [7:0] pat, input logic exp_err);
    int d0 = done_cnt;
    int t = 0;
    push_expect(n, pat);
    pulse_start();
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_err_clear_on_start"}, err, 0);
    drive_bytes(n, pat);
    while (done_cnt == d0 && t < 3000) begin
      @(negedge CLK); #1;
      t++;
    end
    check({tag, "_done_seen"}, (done_cnt != d0), 1);
    repeat (3) @(posedge CLK);
    #1;
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 1);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_aw_drained"}, 64'(exp_awaddr_q.size()), 0);
    check({tag, "_w_drained"}, 64'(exp_wdata_q.size()), 0);
  endtask

  // AXI slave: AW ready after aw_delay waiting cycles, W ready optionally toggling,
  // B answered as soon as BREADY is seen.
  initial begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    forever begin
      @(posedge CLK); #1;
      if (awvalid) begin
        if (aw_wait >= aw_delay) awready = 1'b1;
        else begin
          awready = 1'b0;
          aw_wait++;
        end
      end else begin
        awready = 1'b0;
        aw_wait = 0;
      end
      tog    = ~tog;
      wready = (w_beat_cnt < w_stall_after) && (!w_toggle || tog);
      bvalid = bready;
      bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: scoreboard pops on handshakes, stability and exclusivity checks.
  always @(negedge CLK) begin
    if (!RSTn) begin
      w_beat_cnt = 0;
      aw_open    = 1'b0;
      aw_stall   = 0;
      pa_v = 1'b0; pw_v = 1'b0; pdone = 1'b0;
    end else begin
      if (pa_v && !pa_r) begin
        check("awvalid_hold", awvalid, 1);
        check("awaddr_stable", awaddr, pa_addr);
        check("awlen_stable", awlen, pa_len);
      end
      if (pw_v && !pw_r) begin
        check("wvalid_hold", wvalid, 1);
        check("wdata_stable", wdata, pw_data);
        check("wlast_stable", wlast, pw_last);
      end
      if (awvalid && !awready) aw_stall++;
      if (awvalid && awready) begin
        if (exp_awaddr_q.size() == 0) check("aw_unexpected", awaddr, 64'hDEAD);
        else begin
          check("awaddr", awaddr, exp_awaddr_q.pop_front());
          check("awlen", awlen, exp_awlen_q.pop_front());
          check("awsize", awsize, 3'b011);
          check("awburst", awburst, 2'b01);
        end
        last_aw_stall = aw_stall;
        aw_stall = 0;
        aw_open  = 1'b1;
      end
      if (wvalid) check("wvalid_after_aw", aw_open, 1);
      if (wvalid && wready) begin
        if (exp_wdata_q.size() == 0) check("w_unexpected", wdata, 64'hDEAD);
        else begin
          check("wdata", wdata, exp_wdata_q.pop_front());
          check("wlast", wlast, exp_wlast_q.pop_front());
          check("wstrb", wstrb, 8'hFF);
        end
        w_beat_cnt++;
        if (wlast) begin
          w_beat_cnt = 0;
          aw_open = 1'b0;
        end
      end
      if (bvalid && bready) b_cnt++;
      if (in_ready) check("in_ready_exclusive", {awvalid, wvalid, bready, done}, 0);
      if (pdone) check("done_one_cycle", done, 0);
      if (done) done_cnt++;
      pa_v = awvalid; pa_r = awready; pa_addr = awaddr; pa_len = awlen;
      pw_v = wvalid;  pw_r = wready;  pw_data = wdata;  pw_last = wlast;
      pdone = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wlast", wlast, 0);
    check("rst_bready", bready, 0);
    check("rst_awaddr", awaddr, BASE);
    @(posedge CLK); #1;
    RSTn = 1'b1;
    @(posedge CLK); #1;

    // 16 bytes, two-beat burst
    run_load("t16", 16, 8'h00, 1'b0);

    // 65 bytes, full burst then one-beat tail; a stray start mid-load is ignored
    start_at = 10;
    run_load("t65", 65, 8'h00, 1'b0);
    start_at = -1;

    // Single byte: one zero-padded beat
    run_load("t1", 1, 8'hEE, 1'b0);

    // Slow AW and toggling W
    aw_delay = 5;
    w_toggle = 1'b1;
    run_load("tslow", 100, 8'hA0, 1'b0);
    check("tslow_aw_stall", 64'(last_aw_stall), 5);
    aw_delay = 0;
    w_toggle = 1'b0;

    // Error response on first of two bursts; load continues, err sticky
    err_burst = b_cnt;
    run_load("terr", 100, 8'h30, 1'b1);
    err_burst = -1;
    repeat (5) @(posedge CLK);
    #1;
    check("terr_sticky", err, 1);
    run_load("tclr", 16, 8'h55, 1'b0);

    // Exactly one full burst ending on in_last
    run_load("t64", 64, 8'hC0, 1'b0);

    // Reset while beat 3 of a burst is presented
    w_stall_after = 3;
    push_expect(64, 8'h11);
    pulse_start();
    drive_bytes(64, 8'h11);
    t = 0;
    while (!(wvalid && w_beat_cnt == 3) && t < 500) begin
      @(negedge CLK); #1;
      t++;
    end
    check("trst_reached_beat3", (t < 500), 1);
    RSTn = 1'b0;
    @(negedge CLK);
    check("trst_wvalid", wvalid, 0);
    check("trst_busy", busy, 0);
    check("trst_awvalid", awvalid, 0);
    check("trst_in_ready", in_ready, 0);
    check("trst_bready", bready, 0);
    check("trst_awaddr", awaddr, BASE);
    check("trst_w_left", 64'(exp_wdata_q.size()), 5);
    exp_wdata_q.delete();
    exp_wlast_q.delete();
    w_stall_after = 1000;
    @(posedge CLK); #1;
    RSTn = 1'b1;
    @(posedge CLK); #1;
    run_load("tpost", 72, 8'h77, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
